// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: default widths,
// operand-mux select encodings and the multi-cycle unit FSM state type.
package hazard_fwd_unit_pkg;

  localparam int REG_AW_DEF = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_fwd_unit_fwd_cmp.sv
// Per-source forwarding compare: matches one EX-stage source register
// against the EX/MEM and MEM/WB destinations and priority-encodes the
// operand-mux select, with the younger EX/MEM result winning.
module hfu_fwd_cmp
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_mem_rw,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic              i_wb_rw,
  output logic [1:0]        o_sel
);

  logic w_src_live;
  logic w_mem_hit;
  logic w_wb_hit;

  // A hardwired zero register never needs a forwarded value
  always_comb begin
    w_src_live = !(ZERO_REG && (i_src_addr == '0));
    w_mem_hit  = w_src_live && i_mem_rw && (i_mem_dst == i_src_addr);
    w_wb_hit   = w_src_live && i_wb_rw && (i_wb_dst == i_src_addr);
    o_sel      = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit for the 5-stage pipeline: operand forwarding
// selects, load-use stall, tracking of one multi-cycle op in flight and a
// saturating count of stalled cycles.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int MC_LAT   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic                      id_is_mc,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
  input  logic [REG_AW-1:0]         ex_dst_addr,
  input  logic                      ex_rw,
  input  logic                      ex_is_load,
  input  logic                      ex_is_mc,
  input  logic [REG_AW-1:0]         mem_dst_addr,
  input  logic                      mem_rw,
  input  logic [REG_AW-1:0]         wb_dst_addr,
  input  logic                      wb_rw,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [REG_AW-1:0]         mc_dst,
  output logic                      mc_err,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  mc_state_t         r_state;
  mc_state_t         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [REG_AW-1:0] r_mc_dst;
  logic [REG_AW-1:0] w_mc_dst_nxt;
  logic              r_mc_err;
  logic              w_mc_err_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_load_use;
  logic              w_mc_dep;
  logic              w_mc_stall;
  logic              w_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hfu_fwd_cmp #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_cmp (
      .i_src_addr (ex_src_addr[g*REG_AW +: REG_AW]),
      .i_mem_dst  (mem_dst_addr),
      .i_mem_rw   (mem_rw),
      .i_wb_dst   (wb_dst_addr),
      .i_wb_rw    (wb_rw),
      .o_sel      (fwd_sel[2*g +: 2])
    );
  end

  // Scan ID-stage sources for a dependency on the EX load or the in-flight MC op
  always_comb begin
    w_load_use = 1'b0;
    w_mc_dep   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i] && !(ZERO_REG && (id_src_addr[i*REG_AW +: REG_AW] == '0))) begin
        if (ex_is_load && ex_rw && (id_src_addr[i*REG_AW +: REG_AW] == ex_dst_addr)) begin
          w_load_use = 1'b1;
        end
        if (id_src_addr[i*REG_AW +: REG_AW] == r_mc_dst) begin
          w_mc_dep = 1'b1;
        end
      end
    end
    w_mc_stall = (r_state == BUSY) && (w_mc_dep || id_is_mc);
    w_stall    = w_load_use || w_mc_stall;
  end

  // MC FSM next state; a second issue while busy is dropped and flagged
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mc_dst_nxt = r_mc_dst;
    w_mc_err_nxt = r_mc_err;
    case (r_state)
      IDLE: begin
        if (ex_is_mc) begin
          w_state_nxt  = BUSY;
          w_cnt_nxt    = CW'(MC_LAT - 1);
          w_mc_dst_nxt = ex_dst_addr;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
        end
        if (ex_is_mc) begin
          w_mc_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, MC tracking registers and the saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mc_dst    <= '0;
      r_mc_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mc_dst <= w_mc_dst_nxt;
      r_mc_err <= w_mc_err_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign bubble    = w_stall;
  assign mc_busy   = (r_state == BUSY);
  assign mc_done   = (r_state == BUSY) && (r_cnt == CW'(1));
  assign mc_dst    = r_mc_dst;
  assign mc_err    = r_mc_err;
  assign stall_cnt = r_stall_cnt;

endmodule
